// File: rtl/dpram_rw_pkg.sv
// ============================================================================
// Module      : dpram_rw_pkg
// Description : Shared types, constants and the test-pattern helper for the
//               dual-port RAM write/verify sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dpram_rw_pkg;

    // Sequencer states, in run order.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Supported RAM read latencies.
    localparam int c_rd_lat_min = 1;
    localparam int c_rd_lat_max = 2;

    // Working width of the pattern helper; callers truncate to DATA_W, which
    // gives the silent modulo-2^DATA_W wrap of the pattern.
    localparam int c_pat_w = 32;

    // Word i of a region is seed + region offset + i.
    function automatic logic [c_pat_w-1:0] pattern(
        input logic [c_pat_w-1:0] seed,
        input logic [c_pat_w-1:0] offset,
        input logic [c_pat_w-1:0] index
    );
        return seed + offset + index;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_rw_port.sv
// ============================================================================
// Module      : dpram_rw_port
// Description : One RAM port of the write/verify sequencer: registered
//               address/data generation, expected-value delay line matched
//               to the RAM read latency, and the per-word mismatch flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_rw_port
    import dpram_rw_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int IDX_W     = 5,
    parameter int RD_LAT    = 1,
    parameter int WR_BASE   = 0,
    parameter int RD_BASE   = 0,
    parameter int WR_OFFSET = 0,
    parameter int RD_OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_phase,
    input  logic              rd_phase,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] seed,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              mismatch
);

    localparam logic [ADDR_W-1:0] c_wr_base = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] c_rd_base = ADDR_W'(RD_BASE);

    logic [DATA_W-1:0] w_wr_pat;
    logic [DATA_W-1:0] w_rd_pat;
    // Stage 0 is loaded together with the read address; stage RD_LAT lines
    // up with the data the RAM returns for that address.
    logic [DATA_W-1:0] r_exp [RD_LAT+1];
    logic [RD_LAT:0]   r_vld;

    assign w_wr_pat = DATA_W'(pattern(c_pat_w'(seed), c_pat_w'(WR_OFFSET), c_pat_w'(idx)));
    assign w_rd_pat = DATA_W'(pattern(c_pat_w'(seed), c_pat_w'(RD_OFFSET), c_pat_w'(idx)));

    // Registered RAM command: write word idx, read word idx, or stay idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= c_wr_base;
            ram_wr_data <= '0;
        end else if (wr_phase) begin
            ram_en      <= 1'b1;
            ram_we      <= 1'b1;
            ram_addr    <= c_wr_base + ADDR_W'(idx);
            ram_wr_data <= w_wr_pat;
        end else if (rd_phase) begin
            ram_en      <= 1'b1;
            ram_we      <= 1'b0;
            ram_addr    <= c_rd_base + ADDR_W'(idx);
            ram_wr_data <= '0;
        end else begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= c_wr_base;
            ram_wr_data <= '0;
        end
    end

    // Expected value and valid bit travel alongside each read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                r_exp[k] <= '0;
            end
        end else begin
            r_vld    <= {r_vld[RD_LAT-1:0], rd_phase};
            r_exp[0] <= rd_phase ? w_rd_pat : '0;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_exp[k] <= r_exp[k-1];
            end
        end
    end

    assign mismatch = r_vld[RD_LAT] && (ram_rd_data != r_exp[RD_LAT]);

endmodule

`default_nettype wire

// File: rtl/dpram_rw_checker.sv
// ============================================================================
// Module      : dpram_rw_checker
// Description : Write-then-verify sequencer for a true dual-port RAM. Port A
//               fills region A and port B fills region B with an incrementing
//               pattern, both regions are read back and compared, and the run
//               ends with a done pulse, a pass flag and a mismatch count.
//               Optional macro DPRAM_RW_CROSS_READ_EN: during readback port A
//               reads region B and port B reads region A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_rw_checker
    import dpram_rw_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16,
    parameter int A_BASE = 0,
    parameter int B_BASE = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic              ram_en_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_wr_data_a,
    input  logic [DATA_W-1:0] ram_rd_data_a,
    output logic              ram_en_b,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_wr_data_b,
    input  logic [DATA_W-1:0] ram_rd_data_b
);

    // Index counter: enough bits for DEPTH-1 plus a terminal-detect bit.
    localparam int                 c_idx_w      = $clog2(DEPTH) + 1;
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DEPTH - 1);
    localparam logic [c_idx_w-1:0] c_drain_last = c_idx_w'(RD_LAT - 1);
    localparam int                 c_err_w      = ADDR_W + 1;
    localparam logic [c_err_w-1:0] c_err_max    = {c_err_w{1'b1}};

`ifdef DPRAM_RW_CROSS_READ_EN
    localparam int c_rd_base_a = B_BASE;
    localparam int c_rd_off_a  = DEPTH;
    localparam int c_rd_base_b = A_BASE;
    localparam int c_rd_off_b  = 0;
`else
    localparam int c_rd_base_a = A_BASE;
    localparam int c_rd_off_a  = 0;
    localparam int c_rd_base_b = B_BASE;
    localparam int c_rd_off_b  = DEPTH;
`endif

    // Reject configurations that would overlap regions or overrun the RAM.
    if (RD_LAT < c_rd_lat_min || RD_LAT > c_rd_lat_max) begin : g_bad_rd_lat
        $error("dpram_rw_checker: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > 2**(ADDR_W-1)) begin : g_bad_depth
        $error("dpram_rw_checker: DEPTH out of range 1..2^(ADDR_W-1)");
    end
    if (A_BASE + DEPTH > B_BASE || B_BASE + DEPTH > 2**ADDR_W) begin : g_bad_regions
        $error("dpram_rw_checker: regions overlap or exceed the address space");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [c_idx_w-1:0]  r_idx;
    logic [DATA_W-1:0]   r_seed;
    logic                w_accept;
    logic                w_mis_a;
    logic                w_mis_b;
    logic [c_err_w:0]    w_err_sum;
    logic [c_err_w-1:0]  w_err_next;

    // busy stays high through the done cycle, so this also masks start there.
    assign w_accept = (r_state == ST_IDLE) && start && !busy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)                 w_state_next = ST_WRITE;
            ST_WRITE: if (r_idx == c_idx_last)      w_state_next = ST_READ;
            ST_READ:  if (r_idx == c_idx_last)      w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_idx == c_drain_last)    w_state_next = ST_DONE;
            ST_DONE:                                w_state_next = ST_IDLE;
            default:                                w_state_next = ST_IDLE;
        endcase
    end

    // Index restarts at 0 on every state change and counts within a state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_state_next != r_state || r_state == ST_IDLE) begin
            r_idx <= '0;
        end else begin
            r_idx <= r_idx + c_idx_w'(1);
        end
    end

    // Seed capture on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed <= '0;
        end else if (w_accept) begin
            r_seed <= seed;
        end
    end

    // Up to two mismatches per cycle, saturating at the counter maximum.
    assign w_err_sum  = {1'b0, err_cnt} + {{c_err_w{1'b0}}, w_mis_a} + {{c_err_w{1'b0}}, w_mis_b};
    assign w_err_next = (w_err_sum > {1'b0, c_err_max}) ? c_err_max : w_err_sum[c_err_w-1:0];

    // Status outputs: error count, pass verdict, done pulse and busy window.
    // The last compare lands in the DONE-state cycle, so pass uses w_err_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            pass    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= (r_state == ST_DONE);
            if (w_accept) begin
                err_cnt <= '0;
                pass    <= 1'b0;
                busy    <= 1'b1;
            end else begin
                err_cnt <= w_err_next;
                if (r_state == ST_DONE) begin
                    pass <= (w_err_next == '0);
                end
                if (done) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    dpram_rw_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .IDX_W     (c_idx_w),
        .RD_LAT    (RD_LAT),
        .WR_BASE   (A_BASE),
        .RD_BASE   (c_rd_base_a),
        .WR_OFFSET (0),
        .RD_OFFSET (c_rd_off_a)
    ) u_port_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_phase    (r_state == ST_WRITE),
        .rd_phase    (r_state == ST_READ),
        .idx         (r_idx),
        .seed        (r_seed),
        .ram_en      (ram_en_a),
        .ram_we      (ram_we_a),
        .ram_addr    (ram_addr_a),
        .ram_wr_data (ram_wr_data_a),
        .ram_rd_data (ram_rd_data_a),
        .mismatch    (w_mis_a)
    );

    dpram_rw_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .IDX_W     (c_idx_w),
        .RD_LAT    (RD_LAT),
        .WR_BASE   (B_BASE),
        .RD_BASE   (c_rd_base_b),
        .WR_OFFSET (DEPTH),
        .RD_OFFSET (c_rd_off_b)
    ) u_port_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_phase    (r_state == ST_WRITE),
        .rd_phase    (r_state == ST_READ),
        .idx         (r_idx),
        .seed        (r_seed),
        .ram_en      (ram_en_b),
        .ram_we      (ram_we_b),
        .ram_addr    (ram_addr_b),
        .ram_wr_data (ram_wr_data_b),
        .ram_rd_data (ram_rd_data_b),
        .mismatch    (w_mis_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_dpram_rw_checker.sv
// ============================================================================
// Module      : tb_dpram_rw_checker
// Description : Self-checking bench. Three sequencers share start/seed:
//               dut0 (RD_LAT=1) on a 1-cycle RAM model with read corruption,
//               dut1 (RD_LAT=2) on a 2-cycle model, and dut2 (RD_LAT=1) on a
//               2-cycle model, which must flag every word.
//               Honours DPRAM_RW_CROSS_READ_EN for the readback regions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dpram_rw_checker;

`ifdef DPRAM_RW_CROSS_READ_EN
    localparam int RD_A = 16;
    localparam int RD_B = 0;
`else
    localparam int RD_A = 0;
    localparam int RD_B = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] seed = 8'h00;

    logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [5:0] err0, err1, err2;
    logic a0_en, a0_we, b0_en, b0_we, a1_en, a1_we, b1_en, b1_we, a2_en, a2_we, b2_en, b2_we;
    logic [4:0] a0_addr, b0_addr, a1_addr, b1_addr, a2_addr, b2_addr;
    logic [7:0] a0_wd, b0_wd, a1_wd, b1_wd, a2_wd, b2_wd;
    logic [7:0] a0_rd, b0_rd, a1_rd, b1_rd, a2_rd, b2_rd, a1_s1, b1_s1, a2_s1, b2_s1;

    logic [7:0]  mem0 [32];
    logic [7:0]  mem1 [32];
    logic [7:0]  mem2 [32];
    logic [31:0] bad = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    // Run observations
    int d0_cyc, d1_cyc, d2_cyc, d0_pulses, rd_first_cyc, viol;
    logic [5:0] d0_err, d1_err, d2_err;
    logic d0_pass, d1_pass, d2_pass, busy_c0, busy_end, pass_end;
    logic [4:0] rd_first_addr;

    typedef struct {
        logic [7:0]  seed;
        logic [31:0] bad_mask;
        int          exp_err;
        logic        exp_pass;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    dpram_rw_checker #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .A_BASE(0), .B_BASE(16), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .ram_en_a(a0_en), .ram_we_a(a0_we), .ram_addr_a(a0_addr), .ram_wr_data_a(a0_wd), .ram_rd_data_a(a0_rd),
        .ram_en_b(b0_en), .ram_we_b(b0_we), .ram_addr_b(b0_addr), .ram_wr_data_b(b0_wd), .ram_rd_data_b(b0_rd));

    dpram_rw_checker #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .A_BASE(0), .B_BASE(16), .RD_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .ram_en_a(a1_en), .ram_we_a(a1_we), .ram_addr_a(a1_addr), .ram_wr_data_a(a1_wd), .ram_rd_data_a(a1_rd),
        .ram_en_b(b1_en), .ram_we_b(b1_we), .ram_addr_b(b1_addr), .ram_wr_data_b(b1_wd), .ram_rd_data_b(b1_rd));

    dpram_rw_checker #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .A_BASE(0), .B_BASE(16), .RD_LAT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .ram_en_a(a2_en), .ram_we_a(a2_we), .ram_addr_a(a2_addr), .ram_wr_data_a(a2_wd), .ram_rd_data_a(a2_rd),
        .ram_en_b(b2_en), .ram_we_b(b2_we), .ram_addr_b(b2_addr), .ram_wr_data_b(b2_wd), .ram_rd_data_b(b2_rd));

    // 1-cycle RAM model; words flagged in 'bad' read back with bit 0 flipped.
    // Non-read cycles return FF so stale data never looks valid.
    always @(posedge clk) begin
        if (a0_en && a0_we) mem0[a0_addr] <= a0_wd;
        if (b0_en && b0_we) mem0[b0_addr] <= b0_wd;
        a0_rd <= (a0_en && !a0_we) ? (mem0[a0_addr] ^ {7'd0, bad[a0_addr]}) : 8'hFF;
        b0_rd <= (b0_en && !b0_we) ? (mem0[b0_addr] ^ {7'd0, bad[b0_addr]}) : 8'hFF;
    end

    // 2-cycle RAM model for dut1.
    always @(posedge clk) begin
        if (a1_en && a1_we) mem1[a1_addr] <= a1_wd;
        if (b1_en && b1_we) mem1[b1_addr] <= b1_wd;
        a1_s1 <= (a1_en && !a1_we) ? mem1[a1_addr] : 8'hFF;
        b1_s1 <= (b1_en && !b1_we) ? mem1[b1_addr] : 8'hFF;
        a1_rd <= a1_s1;
        b1_rd <= b1_s1;
    end

    // 2-cycle RAM model for dut2 (latency mismatch).
    always @(posedge clk) begin
        if (a2_en && a2_we) mem2[a2_addr] <= a2_wd;
        if (b2_en && b2_we) mem2[b2_addr] <= b2_wd;
        a2_s1 <= (a2_en && !a2_we) ? mem2[a2_addr] : 8'hFF;
        b2_s1 <= (b2_en && !b2_we) ? mem2[b2_addr] : 8'hFF;
        a2_rd <= a2_s1;
        b2_rd <= b2_s1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One start pulse, then a fixed 40-cycle observation window. Cycle 0 is
    // the negedge right after the edge that samples start. With nag set,
    // start is re-pulsed at cycles 5, 20 (busy) and 34 (done cycle).
    task automatic run(input logic [7:0] s, input bit nag);
        d0_cyc = -1; d1_cyc = -1; d2_cyc = -1; d0_pulses = 0;
        rd_first_cyc = -1; rd_first_addr = '0; viol = 0;
        @(negedge clk);
        seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 0) busy_c0 = busy0 & busy1 & busy2;
            if (done0) begin
                d0_pulses++;
                if (d0_cyc < 0) begin d0_cyc = cyc; d0_err = err0; d0_pass = pass0; end
            end
            if (done1 && d1_cyc < 0) begin d1_cyc = cyc; d1_err = err1; d1_pass = pass1; end
            if (done2 && d2_cyc < 0) begin d2_cyc = cyc; d2_err = err2; d2_pass = pass2; end
            if (a0_en && !a0_we && rd_first_cyc < 0) begin
                rd_first_cyc = cyc;
                rd_first_addr = a0_addr;
            end
            if (a0_en && a0_we && int'(a0_addr) > 15) viol++;
            if (b0_en && b0_we && int'(b0_addr) < 16) viol++;
            if (a0_en && !a0_we && (int'(a0_addr) < RD_A || int'(a0_addr) > RD_A + 15)) viol++;
            if (b0_en && !b0_we && (int'(b0_addr) < RD_B || int'(b0_addr) > RD_B + 15)) viol++;
            start = nag && (cyc == 5 || cyc == 20 || cyc == 34);
        end
        start = 1'b0;
        busy_end = busy0;
        pass_end = pass0;
    endtask

    initial begin
        int bad_words;
        int quiet_done;

        vecs[0] = '{8'h00, 32'h0000_0000, 0, 1'b1};   // plain pattern
        vecs[1] = '{8'hF8, 32'h0000_0000, 0, 1'b1};   // port A wraps FF -> 00
        vecs[2] = '{8'h00, 32'h0010_0000, 1, 1'b0};   // address 20 corrupted
        vecs[3] = '{8'h00, 32'h0008_0008, 2, 1'b0};   // 3 and 19, same read cycle
        vecs[4] = '{8'h55, 32'h8000_0001, 2, 1'b0};   // region edges 0 and 31

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy0}, 0);
        check("rst_done", {31'd0, done0}, 0);
        check("rst_pass", {31'd0, pass0}, 0);
        check("rst_err_cnt", {26'd0, err0}, 0);
        check("rst_en_we", {30'd0, a0_en, a0_we, b0_en, b0_we} >> 0, 0);
        check("rst_addr_a", {27'd0, a0_addr}, 0);
        check("rst_addr_b", {27'd0, b0_addr}, 16);
        check("rst_wr_data", {16'd0, a0_wd, b0_wd}, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            bad = vecs[v].bad_mask;
            run(vecs[v].seed, 1'b0);
            check("busy_after_start", {31'd0, busy_c0}, 1);
            check("done_cycle", d0_cyc, 34);
            check("err_cnt", {26'd0, d0_err}, vecs[v].exp_err);
            check("pass", {31'd0, d0_pass}, {31'd0, vecs[v].exp_pass});
            check("done_pulse_cycles", d0_pulses, 1);
            check("busy_after_done", {31'd0, busy_end}, 0);
            check("pass_held", {31'd0, pass_end}, {31'd0, vecs[v].exp_pass});
            check("first_read_addr_a", {27'd0, rd_first_addr}, RD_A);
            check("first_read_cycle", rd_first_cyc, 17);
            check("region_violations", viol, 0);
            bad_words = 0;
            for (int j = 0; j < 32; j++) begin
                if (mem0[j] !== 8'(vecs[v].seed + j)) bad_words++;
            end
            check("ram_contents", bad_words, 0);
            check("lat2_done_cycle", d1_cyc, 35);
            check("lat2_pass", {31'd0, d1_pass}, 1);
            check("lat2_err_cnt", {26'd0, d1_err}, 0);
            check("latmis_err_cnt", {26'd0, d2_err}, 32);
            check("latmis_pass", {31'd0, d2_pass}, 0);
        end

        // Start pulses while busy and in the done cycle are ignored.
        bad = 32'h0;
        run(8'h10, 1'b1);
        check("nag_done_cycle", d0_cyc, 34);
        check("nag_pass", {31'd0, d0_pass}, 1);
        check("nag_done_pulses", d0_pulses, 1);
        check("nag_busy_after", {31'd0, busy_end}, 0);

        // Reset in the middle of READ aborts with no done pulse.
        @(negedge clk);
        seed = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_reading", {30'd0, a0_en, a0_we}, 2);
        rst_n = 1'b0;
        #1;
        check("abort_en_a", {31'd0, a0_en}, 0);
        check("abort_addr_a", {27'd0, a0_addr}, 0);
        check("abort_addr_b", {27'd0, b0_addr}, 16);
        check("abort_busy", {31'd0, busy0}, 0);
        check("abort_err_cnt", {26'd0, err0}, 0);
        quiet_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0) quiet_done++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done0 || busy0) quiet_done++;
        end
        check("abort_no_done", quiet_done, 0);

        run(8'h00, 1'b0);
        check("post_abort_done_cycle", d0_cyc, 34);
        check("post_abort_pass", {31'd0, d0_pass}, 1);
        check("post_abort_err_cnt", {26'd0, d0_err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
